clk_enable_manager: RTL and testbench

Parametrised clock-enable and reset sequencer for the CPU top level. It takes the single board clock and an asynchronous active-high reset, and produces a synchronised, stretched system reset. It also produces NUM_CH independent clock-enable channels. Each channel either free-runs at a programmable divide ratio or single-steps on request, for manual CPU stepping from a push switch.

---
 rtl/clk_enable_manager.sv | 119 +++++++++++
 tb/tb_clk_enable_manager.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_manager.sv
// Reset sequencer and per-channel clock-enable generator (free-run divide or single-step).
// Outputs decode from registered state only; no backpressure, enables are one-cycle pulses.
module clk_enable_manager #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       step_mode,
  input  logic [NUM_CH-1:0]       step_req,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       step_ack,
  output logic                    sync_rst,
  output logic                    rst_done
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   sync_ff;
  logic [HOLD_W-1:0]        hold_cnt, hold_cnt_nxt;
  logic                     run;

  logic [DIV_W-1:0]         div_q [NUM_CH];
  logic [DIV_W-1:0]         cnt   [NUM_CH];
  logic [NUM_CH-1:0]        mode_q;
  logic [NUM_CH-1:0]        step_q;
  logic [NUM_CH-1:0]        req_prev;

  // Async set, synchronous release of the reset into the core domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '1;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RESET;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      ST_RESET: begin
        if (!sync_ff[SYNC_STAGES-1]) begin
          state_nxt    = ST_HOLD;
          hold_cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_nxt = ST_RUN;
        else                                   hold_cnt_nxt = hold_cnt + HOLD_W'(1);
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_RESET;
    endcase
  end

  assign run      = (state == ST_RUN);
  assign sync_rst = ~run;
  assign rst_done = run;

  // Mode is registered so a mode flip never reaches the outputs combinationally;
  // the flip itself restarts the channel from a clean counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= '0;
        cnt[i]   <= '0;
      end
      mode_q   <= '0;
      step_q   <= '0;
      req_prev <= '0;
    end else begin
      req_prev <= step_req;
      mode_q   <= step_mode;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_load) div_q[i] <= div_cfg[i*DIV_W +: DIV_W];
        if (step_mode[i] != mode_q[i]) begin
          cnt[i]    <= '0;
          step_q[i] <= 1'b0;
        end else if (mode_q[i]) begin
          cnt[i]    <= '0;
          step_q[i] <= run & step_req[i] & ~req_prev[i];
        end else begin
          step_q[i] <= 1'b0;
          if (cfg_load || !run || (cnt[i] == div_q[i])) cnt[i] <= '0;
          else                                          cnt[i] <= cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    ch_en    = '0;
    step_ack = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      step_ack[i] = step_q[i];
      ch_en[i]    = step_q[i] | (~mode_q[i] & run & (cnt[i] == div_q[i]));
    end
  end

endmodule

// File: tb/tb_clk_enable_manager.sv
// Bench for clk_enable_manager: directed sequence plus random traffic against an
// edge-counting reference model (pulse phase derived from modular arithmetic).
module tb_clk_enable_manager;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 16;
  localparam int SS       = 2;
  localparam int RH       = 16;
  localparam int RUN_EDGE = SS + RH + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH*DIV_W-1:0] div_cfg;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       step_mode;
  logic [NUM_CH-1:0]       step_req;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       step_ack;
  logic                    sync_rst;
  logic                    rst_done;

  clk_enable_manager #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SYNC_STAGES(SS), .RST_HOLD(RH)
  ) dut (
    .clk(clk), .rst(rst), .div_cfg(div_cfg), .cfg_load(cfg_load),
    .step_mode(step_mode), .step_req(step_req), .ch_en(ch_en),
    .step_ack(step_ack), .sync_rst(sync_rst), .rst_done(rst_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edges since reset release, and per channel the edge at which
  // its divide phase restarted, the ratio, the settled mode and the last request.
  int edge_n;
  int m_div    [NUM_CH];
  int m_origin [NUM_CH];
  bit m_mode   [NUM_CH];
  bit m_prev   [NUM_CH];
  bit m_pulse  [NUM_CH];

  function automatic void model_reset();
    edge_n = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = 0; m_origin[c] = 0; m_mode[c] = 0; m_prev[c] = 0; m_pulse[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit running_before;
    running_before = (edge_n >= RUN_EDGE);
    edge_n++;
    for (int c = 0; c < NUM_CH; c++) begin
      bit changed;
      changed    = (step_mode[c] != m_mode[c]);
      m_pulse[c] = !changed && m_mode[c] && running_before && step_req[c] && !m_prev[c];
      if (cfg_load) begin
        m_div[c]    = int'(div_cfg[c*DIV_W +: DIV_W]);
        m_origin[c] = edge_n;
      end
      if (changed) m_origin[c] = edge_n;
      m_mode[c] = step_mode[c];
      m_prev[c] = step_req[c];
    end
  endfunction

  task automatic expected(output logic [NUM_CH-1:0] en, output logic [NUM_CH-1:0] ack,
                          output logic srst, output logic done);
    bit run;
    run  = (edge_n >= RUN_EDGE);
    srst = !run;
    done = run;
    for (int c = 0; c < NUM_CH; c++) begin
      int org;
      org = (m_origin[c] > RUN_EDGE) ? m_origin[c] : RUN_EDGE;
      if (m_mode[c]) begin
        en[c]  = m_pulse[c];
        ack[c] = m_pulse[c];
      end else begin
        en[c]  = run && (((edge_n - org) % (m_div[c] + 1)) == m_div[c]);
        ack[c] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0] e_en, e_ack;
    logic e_srst, e_done;
    expected(e_en, e_ack, e_srst, e_done);
    check({tag, ".ch_en"},    32'(ch_en),    32'(e_en));
    check({tag, ".step_ack"}, 32'(step_ack), 32'(e_ack));
    check({tag, ".sync_rst"}, 32'(sync_rst), 32'(e_srst));
    check({tag, ".rst_done"}, 32'(rst_done), 32'(e_done));
  endtask

  // Inputs only change at negedge, so at posedge they hold what the DUT samples.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Called at a negedge: reset lands mid-cycle and must act without a clock edge.
  task automatic mid_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs(tag);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    logic found;
    rst = 1'b0; div_cfg = '0; cfg_load = 1'b0; step_mode = '0; step_req = '0;
    #1 rst = 1'b1;
    #1 model_reset();
    check_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset release and default all-ones enables
    for (int k = 0; k < 25; k++) cycle("release");
    check("edge_count_run", 32'(rst_done), 32'(1));

    // Divide ratios 4 and 2
    div_cfg = {16'd1, 16'd3}; cfg_load = 1'b1;
    cycle("load_div");
    cfg_load = 1'b0;
    for (int k = 0; k < 14; k++) cycle("divide");

    // Reload exactly on a ch0 pulse cycle
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && ch_en[0]) found = 1'b1;
      if (!found) cycle("seek_pulse");
    end
    check("pulse_seen", 32'(ch_en[0]), 32'(1));
    div_cfg = {16'd1, 16'd1}; cfg_load = 1'b1;
    cycle("load_on_pulse");
    cfg_load = 1'b0;
    for (int k = 0; k < 8; k++) cycle("after_reload");

    // Single step on ch1 with a long request
    step_mode = 2'b10;
    for (int k = 0; k < 3; k++) cycle("to_step");
    step_req[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cycle("step_hold");
      pulses += int'(ch_en[1]);
    end
    check("step_pulse_count", 32'(pulses), 32'(1));
    step_req[1] = 1'b0;
    for (int k = 0; k < 3; k++) cycle("step_drop");

    // Largest divisor: no pulse within a short window
    step_mode = 2'b00;
    div_cfg = {16'd2, 16'hFFFF}; cfg_load = 1'b1;
    cycle("load_max");
    cfg_load = 1'b0;
    for (int k = 0; k < 150; k++) cycle("div_max");

    // Reset during HOLD
    mid_reset("rst_run");
    for (int k = 0; k < 10; k++) cycle("hold_part");
    mid_reset("rst_hold");

    // Request held across reset must not fire
    step_mode = 2'b01; step_req = 2'b01;
    for (int k = 0; k < 8; k++) cycle("pre_run_step");
    mid_reset("rst_step");
    pulses = 0;
    for (int k = 0; k < 26; k++) begin
      cycle("held_req");
      pulses += int'(ch_en[0]);
    end
    check("held_req_no_pulse", 32'(pulses), 32'(0));
    step_req[0] = 1'b0;
    cycle("req_low");
    step_req[0] = 1'b1;
    cycle("req_rise");
    check("req_rise_pulse", 32'(ch_en[0]), 32'(1));
    cycle("req_after");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cfg_load = ($urandom_range(9) == 0);
      if (cfg_load) div_cfg = {16'($urandom_range(4)), 16'($urandom_range(4))};
      if ($urandom_range(19) == 0) begin
        int c;
        c = int'($urandom_range(NUM_CH - 1));
        step_mode[c] = ~step_mode[c];
      end
      step_req = 2'($urandom_range(3));
      if (k == 200) mid_reset("rst_random");
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
